// File: rtl/spislave.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : spislave
//  Description : SPI mode-0 target with CPU register interface; external
//                sck/mosi/ss_n are oversampled in the clk domain.
//  Revision    : 1.0  initial release
// ============================================================================
module spislave #(
    parameter logic [15:0] IDLE_TX = 16'hFFFF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] AD,
    input  logic [7:0] DI,
    output logic [7:0] DO,
    input  logic       rw,
    input  logic       cs,
    output logic       irq,
    input  logic       sck,
    input  logic       mosi,
    input  logic       ss_n,
    output logic       miso,
    output logic       miso_oe
);

    logic        r_sck_s1, r_sck_s2, r_sck_p;
    logic        r_mosi_s1, r_mosi_s2;
    logic        r_ss_s1, r_ss_s2, r_ss_p;
    logic [15:0] r_tx_buf, r_shift, r_rx_shift, r_rx_data;
    logic [4:0]  r_bitcnt;
    logic        r_word_done, r_miso, r_txe, r_rxf, r_ovr, r_b16, r_ie;
    logic [7:0]  r_do;

    logic        w_sel, w_ss_fall, w_ss_rise, w_sck_rise, w_sck_fall;
    logic        w_load, w_shift, w_bit, w_done;
    logic        w_wr, w_rd, w_wr_hi, w_wr_lo, w_wr_ctl, w_rd_lo;
    logic [15:0] w_load_word, w_shift_word, w_rx_word;
    logic [7:0]  w_status;

    assign w_sel      = ~r_ss_s2;
    assign w_ss_fall  = r_ss_p & ~r_ss_s2;
    assign w_ss_rise  = ~r_ss_p & r_ss_s2;
    assign w_sck_rise = r_sck_s2 & ~r_sck_p & w_sel;
    assign w_sck_fall = ~r_sck_s2 & r_sck_p & w_sel;

    // The trailing fall of a finished word already fetches the next TX word.
    assign w_load  = w_ss_fall | (w_sck_fall & r_word_done);
    assign w_shift = w_sck_fall & ~r_word_done & (r_bitcnt != 5'd0);
    assign w_bit   = w_sck_rise & (r_bitcnt != 5'd0);
    assign w_done  = w_bit & (r_bitcnt == 5'd1);

    assign w_load_word  = r_txe ? IDLE_TX : r_tx_buf;
    assign w_shift_word = {r_shift[14:0], 1'b1};
    assign w_rx_word    = {r_rx_shift[14:0], r_mosi_s2};

    assign w_wr     = cs & ~rw & ~AD[2];
    assign w_rd     = cs & rw;
    assign w_wr_hi  = w_wr & (AD[1:0] == 2'd0);
    assign w_wr_lo  = w_wr & (AD[1:0] == 2'd1);
    assign w_wr_ctl = w_wr & (AD[1:0] == 2'd2);
    assign w_rd_lo  = w_rd & (AD == 3'd1);
    assign w_status = {r_rxf, r_txe, r_ovr, w_sel, r_b16, 2'b00, r_ie};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sck_s1    <= 1'b0;
            r_sck_s2    <= 1'b0;
            r_sck_p     <= 1'b0;
            r_mosi_s1   <= 1'b1;
            r_mosi_s2   <= 1'b1;
            r_ss_s1     <= 1'b1;
            r_ss_s2     <= 1'b1;
            r_ss_p      <= 1'b1;
            r_tx_buf    <= IDLE_TX;
            r_shift     <= 16'hFFFF;
            r_rx_shift  <= 16'hFFFF;
            r_rx_data   <= 16'hFFFF;
            r_bitcnt    <= 5'd0;
            r_word_done <= 1'b0;
            r_miso      <= 1'b1;
            r_txe       <= 1'b1;
            r_rxf       <= 1'b0;
            r_ovr       <= 1'b0;
            r_b16       <= 1'b0;
            r_ie        <= 1'b0;
            r_do        <= 8'h00;
        end else begin
            r_sck_s1  <= sck;
            r_sck_s2  <= r_sck_s1;
            r_sck_p   <= r_sck_s2;
            r_mosi_s1 <= mosi;
            r_mosi_s2 <= r_mosi_s1;
            r_ss_s1   <= ss_n;
            r_ss_s2   <= r_ss_s1;
            r_ss_p    <= r_ss_s2;

            if (w_ss_rise) begin
                r_bitcnt    <= 5'd0;
                r_word_done <= 1'b0;
                r_miso      <= 1'b1;
                r_shift     <= 16'hFFFF;
            end else if (w_load) begin
                r_shift     <= w_load_word;
                r_miso      <= r_b16 ? w_load_word[15] : w_load_word[7];
                r_bitcnt    <= r_b16 ? 5'd16 : 5'd8;
                r_word_done <= 1'b0;
            end else if (w_bit) begin
                r_rx_shift <= w_rx_word;
                r_bitcnt   <= r_bitcnt - 5'd1;
                if (w_done) begin
                    r_word_done <= 1'b1;
                    r_rx_data   <= r_b16 ? w_rx_word : {8'h00, w_rx_word[7:0]};
                end
            end else if (w_shift) begin
                r_shift <= w_shift_word;
                r_miso  <= r_b16 ? w_shift_word[15] : w_shift_word[7];
            end

            if (w_wr_hi) r_tx_buf[15:8] <= DI;
            if (w_wr_lo) r_tx_buf[7:0]  <= DI;

            // A commit on a load cycle stays queued for the next word.
            if (w_wr_lo)     r_txe <= 1'b0;
            else if (w_load) r_txe <= 1'b1;

            if (w_done)       r_rxf <= 1'b1;
            else if (w_rd_lo) r_rxf <= 1'b0;

            if (w_done && r_rxf)         r_ovr <= 1'b1;
            else if (w_wr_ctl && DI[5])  r_ovr <= 1'b0;

            if (w_wr_ctl) begin
                r_ie <= DI[0];
                if (!w_sel) r_b16 <= DI[4];
            end

            if (w_rd) begin
                if (AD[2]) begin
                    r_do <= 8'h00;
                end else begin
                    case (AD[1:0])
                        2'd0:    r_do <= r_rx_data[15:8];
                        2'd1:    r_do <= r_rx_data[7:0];
                        2'd2:    r_do <= w_status;
                        default: r_do <= 8'h00;
                    endcase
                end
            end
        end
    end

    assign DO      = r_do;
    assign irq     = r_ie & (r_rxf | r_ovr);
    assign miso    = r_miso;
    assign miso_oe = w_sel;

endmodule
`default_nettype wire
